pwm_decoder: RTL

Recovers the N-bit on-time code from a PWM bitstream of the format produced by the soundgen PWM DAC. The block sits on the receive side of a DAC loopback path and feeds captured duty values to the sample checker or to a future audio-capture path. It synchronises the asynchronous PWM line, measures the high and low time of every frame, validates the frame length against 2^N clocks and emits one code per good frame. Stuck-line cases (code 0 or full-on) are resolved by timeout.

---
 rtl/soundgen_pkg.sv | 20 ++
 rtl/sync2.sv | 32 +++
 rtl/pwm_decoder.sv | 129 ++++++++++++
 3 files changed

// File: rtl/soundgen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : soundgen_pkg
// Purpose  : Constants and FSM encoding shared by the soundgen PWM DAC and
//            the PWM decoder on the loopback receive path.
// Revision : 1.0
// ============================================================================
package soundgen_pkg;

    localparam int unsigned c_N_DEFAULT      = 8;
    localparam int unsigned c_PERIOD_DEFAULT = 1 << c_N_DEFAULT;

    typedef enum logic [1:0] {
        SYNC = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Purpose  : Generic two-flop synchroniser for asynchronous inputs.
// Revision : 1.0
// ============================================================================
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_s1_q;
    logic [WIDTH-1:0] r_s2_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_q <= '0;
            r_s2_q <= '0;
        end else begin
            r_s1_q <= d;
            r_s2_q <= r_s1_q;
        end
    end

    assign q = r_s2_q;

endmodule
`default_nettype wire

// File: rtl/pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pwm_decoder
// Purpose  : Recovers the N-bit on-time code from a soundgen PWM bitstream,
//            flags wrong-length frames and resolves stuck lines by timeout.
// Revision : 1.0
// ============================================================================
module pwm_decoder
    import soundgen_pkg::*;
#(
    parameter int unsigned N = c_N_DEFAULT
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pwm_in,
    output logic [N-1:0] t_on_out,
    output logic         valid,
    output logic         period_err,
    output logic         stuck
);

    localparam logic [N:0]   c_PERIOD     = {1'b1, {N{1'b0}}};
    localparam logic [N:0]   c_CNT_ONE    = {{N{1'b0}}, 1'b1};
    localparam logic [N+1:0] c_PERIOD_SUM = {2'b01, {N{1'b0}}};

    logic         w_s2;
    logic         r_s3_q;
    logic         w_rise;
    logic         w_fall;
    logic         w_timeout;
    state_e       r_state_q, w_state_d;
    logic [N:0]   r_hi_cnt_q, w_hi_cnt_d;
    logic [N:0]   r_lo_cnt_q, w_lo_cnt_d;
    logic [N:0]   w_hi_inc;
    logic [N:0]   w_lo_inc;
    logic [N+1:0] w_frame_len;
    logic [N-1:0] r_t_on_q, w_t_on_d;
    logic         r_valid_q, w_valid_d;
    logic         r_period_err_q, w_period_err_d;
    logic         r_stuck_q, w_stuck_d;

    sync2 #(
        .WIDTH (1)
    ) u_sync2 (
        .clk   (clk),
        .reset (reset),
        .d     (pwm_in),
        .q     (w_s2)
    );

    assign w_rise      = w_s2 & ~r_s3_q;
    assign w_fall      = ~w_s2 & r_s3_q;
    assign w_hi_inc    = (r_hi_cnt_q == c_PERIOD) ? r_hi_cnt_q : r_hi_cnt_q + c_CNT_ONE;
    assign w_lo_inc    = (r_lo_cnt_q == c_PERIOD) ? r_lo_cnt_q : r_lo_cnt_q + c_CNT_ONE;
    assign w_frame_len = {1'b0, r_hi_cnt_q} + {1'b0, r_lo_cnt_q};
    // Timeout fires on the edge where the counter of the current level would hit PERIOD.
    assign w_timeout   = w_s2 ? (w_hi_inc == c_PERIOD) : (w_lo_inc == c_PERIOD);

    always_comb begin
        w_state_d      = r_state_q;
        w_hi_cnt_d     = r_hi_cnt_q;
        w_lo_cnt_d     = r_lo_cnt_q;
        w_t_on_d       = r_t_on_q;
        w_valid_d      = 1'b0;
        w_period_err_d = 1'b0;
        w_stuck_d      = r_stuck_q;

        if (w_rise) begin
            // Only a frame measured from a previous rise may be published.
            if (r_state_q == LOW) begin
                if (w_frame_len == c_PERIOD_SUM) begin
                    w_t_on_d  = r_hi_cnt_q[N-1:0];
                    w_valid_d = 1'b1;
                end else begin
                    w_period_err_d = 1'b1;
                end
            end
            w_hi_cnt_d = c_CNT_ONE;
            w_lo_cnt_d = '0;
            w_stuck_d  = 1'b0;
            w_state_d  = HIGH;
        end else if (w_fall) begin
            w_lo_cnt_d = c_CNT_ONE;
            if (r_state_q == HIGH) begin
                w_state_d = LOW;
            end
        end else if (w_timeout) begin
            w_t_on_d   = w_s2 ? {N{1'b1}} : {N{1'b0}};
            w_valid_d  = 1'b1;
            w_stuck_d  = 1'b1;
            w_hi_cnt_d = '0;
            w_lo_cnt_d = '0;
            w_state_d  = SYNC;
        end else if (w_s2) begin
            w_hi_cnt_d = w_hi_inc;
        end else begin
            w_lo_cnt_d = w_lo_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s3_q         <= 1'b0;
            r_state_q      <= SYNC;
            r_hi_cnt_q     <= '0;
            r_lo_cnt_q     <= '0;
            r_t_on_q       <= '0;
            r_valid_q      <= 1'b0;
            r_period_err_q <= 1'b0;
            r_stuck_q      <= 1'b0;
        end else begin
            r_s3_q         <= w_s2;
            r_state_q      <= w_state_d;
            r_hi_cnt_q     <= w_hi_cnt_d;
            r_lo_cnt_q     <= w_lo_cnt_d;
            r_t_on_q       <= w_t_on_d;
            r_valid_q      <= w_valid_d;
            r_period_err_q <= w_period_err_d;
            r_stuck_q      <= w_stuck_d;
        end
    end

    assign t_on_out   = r_t_on_q;
    assign valid      = r_valid_q;
    assign period_err = r_period_err_q;
    assign stuck      = r_stuck_q;

endmodule
`default_nettype wire
